// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master.
//   - FSM state encoding used by spi_master
//   - byte width of one transfer
//   - mode-0 clock polarity / phase constants
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Mode 0: clock idles low, data sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    SPI_IDLE  = 3'd0,
    SPI_SETUP = 3'd1,
    SPI_LOW   = 3'd2,
    SPI_HIGH  = 3'd3,
    SPI_HOLD  = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: loadable 8-bit down-counter pacing the SPI master FSM.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-low reset
//   load     in  reload the counter with load_val this edge
//   load_val in  reload value (phase length minus one)
//   tick     out high while the counter sits at zero
module spi_tick_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tick = (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// spi_master: byte-oriented mode-0 SPI master with per-direction bit order.
// Ports:
//   clk      in  system clock (only clock)
//   reset    in  synchronous active-low reset
//   start    in  request a byte transfer (ignored while busy)
//   keep_cs  in  sampled with start; 1 = leave cs low after this byte
//   tx_data  in  byte to send, captured on accepted start
//   rx_data  out received byte, updated with done
//   busy     out transfer in progress
//   done     out one-cycle pulse at end of byte
//   spi_clk  out SPI clock, idles low
//   mosi     out master data out
//   miso     in  slave data in
//   cs       out chip select, active low
//
// state     | meaning
// ----------+--------------------------------------------------------
// SPI_IDLE  | no transfer; cs may still be low after a kept byte
// SPI_SETUP | cs low, first mosi bit settling before the first rise
// SPI_LOW   | spi_clk low between bits, next mosi bit settling
// SPI_HIGH  | spi_clk high; miso captured on entry
// SPI_HOLD  | after last fall, cs held low for two half-periods
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter bit          TX_LSB_FIRST = 1'b1,
  parameter bit          RX_LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       keep_cs,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  spi_state_t state, state_nxt;

  logic tick;
  logic load_div;
  logic accept, sample, shift, finish, rearm;
  logic lead_sample;

  logic [2:0] bit_cnt;
  logic       bit_last;
  logic       hold_second;
  logic       keep_q;

  logic [SPI_BYTE_W-1:0] tx_sh;
  logic [SPI_BYTE_W-1:0] rx_sh;
  logic [SPI_BYTE_W-1:0] tx_shifted;
  logic [SPI_BYTE_W-1:0] rx_next;
  logic                  tx_first;
  logic                  shifted_first;

  // Mode 0 captures miso on the leading clock edge.
  assign lead_sample = (SPI_CPHA == 1'b0);

  // Bit-order muxing for both directions.
  assign tx_first      = TX_LSB_FIRST ? tx_data[0] : tx_data[SPI_BYTE_W-1];
  assign tx_shifted    = TX_LSB_FIRST ? {1'b0, tx_sh[SPI_BYTE_W-1:1]}
                                      : {tx_sh[SPI_BYTE_W-2:0], 1'b0};
  assign shifted_first = TX_LSB_FIRST ? tx_shifted[0] : tx_shifted[SPI_BYTE_W-1];
  assign rx_next       = RX_LSB_FIRST ? {miso, rx_sh[SPI_BYTE_W-1:1]}
                                      : {rx_sh[SPI_BYTE_W-2:0], miso};

  spi_tick_gen u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (load_div),
    .load_val (DIV_RELOAD),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SPI_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    rearm     = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SPI_SETUP;
        end
      end
      SPI_SETUP, SPI_LOW: begin
        if (tick) begin
          sample    = lead_sample;
          state_nxt = SPI_HIGH;
        end
      end
      SPI_HIGH: begin
        if (tick) begin
          if (bit_last) begin
            state_nxt = SPI_HOLD;
          end else begin
            shift     = 1'b1;
            state_nxt = SPI_LOW;
          end
        end
      end
      SPI_HOLD: begin
        // Two divider periods so cs rises a full SPI period after the last fall.
        if (tick) begin
          if (hold_second) begin
            finish    = 1'b1;
            state_nxt = SPI_IDLE;
          end else begin
            rearm = 1'b1;
          end
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  // Divider restarts on every state change and at the HOLD midpoint.
  assign load_div = (state_nxt != state) || rearm;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_data     <= 8'h00;
      bit_cnt     <= 3'd0;
      bit_last    <= 1'b0;
      hold_second <= 1'b0;
      keep_q      <= 1'b0;
      cs          <= 1'b1;
      mosi        <= 1'b0;
      spi_clk     <= SPI_CPOL;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= finish;
      busy    <= (state_nxt != SPI_IDLE);
      spi_clk <= (state_nxt == SPI_HIGH) ? ~SPI_CPOL : SPI_CPOL;

      if (accept) begin
        tx_sh       <= tx_data;
        rx_sh       <= '0;
        keep_q      <= keep_cs;
        cs          <= 1'b0;
        mosi        <= tx_first;
        bit_cnt     <= 3'd0;
        bit_last    <= 1'b0;
        hold_second <= 1'b0;
      end

      if (shift) begin
        tx_sh <= tx_shifted;
        mosi  <= shifted_first;
      end

      if (sample) begin
        rx_sh <= rx_next;
        if (bit_cnt == 3'(SPI_BYTE_W - 1)) begin
          bit_last <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end

      if (rearm) begin
        hold_second <= 1'b1;
      end

      if (finish) begin
        rx_data     <= rx_sh;
        hold_second <= 1'b0;
        if (!keep_q) begin
          cs   <= 1'b1;
          mosi <= 1'b0;
        end
      end
    end
  end

endmodule
